// File: rtl/snap_vacc_capture_ctrl.sv
// Snapshot capture sequencer for a vacc snap BRAM: arm, trigger, optional delay,
// then one-shot or circular writes, with a status/address word for the PowerPC.
module snap_vacc_capture_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int TRIG_DLY_W = 8
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_in,
  input  logic              ext_trig,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [31:0]       status_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t                state_q, state_d;
  logic [2:0]            ctrl_cur_q, ctrl_prev_q;  // {stop, sw_trig, arm}
  logic [TRIG_DLY_W-1:0] dly_q, dly_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  done_q, done_d;

  logic                  arm_rise, trig_rise, stop_rise, trigger, circular;
  logic [TRIG_DLY_W-1:0] trig_delay;
  logic                  unused_ctrl;

  assign circular    = ctrl_in[2];
  assign trig_delay  = ctrl_in[8 +: TRIG_DLY_W];
  assign unused_ctrl = ^{ctrl_in[31:8+TRIG_DLY_W], ctrl_in[7:4]};

  // Only rising edges of the registered control bits act; held levels are ignored.
  assign arm_rise  = ctrl_cur_q[0] & ~ctrl_prev_q[0];
  assign trig_rise = ctrl_cur_q[1] & ~ctrl_prev_q[1];
  assign stop_rise = ctrl_cur_q[2] & ~ctrl_prev_q[2];
  assign trigger   = ext_trig | trig_rise;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= S_IDLE;
      ctrl_cur_q  <= '0;
      ctrl_prev_q <= '0;
      dly_q       <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_cur_q  <= {ctrl_in[3], ctrl_in[1], ctrl_in[0]};
      ctrl_prev_q <= ctrl_cur_q;
      dly_q       <= dly_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      wrapped_q   <= wrapped_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every variable gets a hold default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    wrapped_d   = wrapped_q;
    done_d      = done_q;

    if (arm_rise) begin
      // Arm from any state (re)starts a capture and clears the status word.
      state_d     = S_ARMED;
      addr_d      = '0;
      last_addr_d = '0;
      wrapped_d   = 1'b0;
      done_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          if (trigger) begin
            dly_d   = trig_delay;
            state_d = (trig_delay == '0) ? S_CAPTURE : S_DELAY;
          end
        end
        S_DELAY: begin
          dly_d = dly_q - 1'b1;
          if (dly_q <= 1) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (din_valid) begin
            last_addr_d = addr_q;
            addr_d      = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
              if (circular) wrapped_d = 1'b1;
              else begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end
          // A write in the stop cycle still lands before entering DONE.
          if (stop_rise) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bram_addr = addr_q;
  assign bram_we   = (state_q == S_CAPTURE) & din_valid;

  always_comb begin
    status_out             = '0;
    status_out[ADDR_W-1:0] = last_addr_q;
    status_out[30]         = wrapped_q;
    status_out[31]         = done_q;
  end

endmodule

// File: tb/tb_snap_vacc_capture_ctrl.sv
// Scoreboard bench for snap_vacc_capture_ctrl (ADDR_W=4): stimulus pushes expected
// write addresses, a negedge monitor pops and compares on every bram_we.
module tb_snap_vacc_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          user_clk   = 1'b0;
  logic          user_rst_n = 1'b0;
  logic          arm = 1'b0, sw_trig = 1'b0, circ = 1'b0, stop = 1'b0;
  logic [DW-1:0] tdly = '0;
  logic [31:0]   ctrl_in;
  logic          ext_trig = 1'b0, din_valid = 1'b0;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [31:0]   status_out;

  assign ctrl_in = {16'h0, tdly, 4'h0, stop, circ, sw_trig, arm};

  int            checks = 0, errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_exp;
  int            cyc = 0, wr_cnt = 0, first_wr = -1, last_wr = -1;

  always #5 user_clk = ~user_clk;

  snap_vacc_capture_ctrl #(.ADDR_W(AW), .TRIG_DLY_W(DW)) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .ctrl_in   (ctrl_in),
    .ext_trig  (ext_trig),
    .din_valid (din_valid),
    .bram_addr (bram_addr),
    .bram_we   (bram_we),
    .status_out(status_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge user_clk) cyc++;

  always @(negedge user_clk) begin
    if (user_rst_n && bram_we) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write", bram_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr", {28'h0, bram_addr}, {28'h0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(AW'(a));
  endtask

  task automatic reset_win();
    wr_cnt   = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  task automatic rearm();
    arm = 1'b0;
    tick();
    arm = 1'b1;
    ticks(2);
  endtask

  task automatic pulse_ext();
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (status_out[31]) break;
      tick();
    end
    check(name, {31'h0, status_out[31]}, 32'h1);
  endtask

  initial begin
    int n;
    int lat;

    // Reset state, observed while reset is still asserted and after release.
    din_valid = 1'b1;
    ticks(3);
    check("rst_addr", {28'h0, bram_addr}, 32'h0);
    check("rst_we", {31'h0, bram_we}, 32'h0);
    check("rst_status", status_out, 32'h0);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    ticks(2);
    check("idle_status", status_out, 32'h0);

    // Triggers while IDLE must not write.
    reset_win();
    pulse_ext();
    sw_trig = 1'b1;
    ticks(2);
    sw_trig = 1'b0;
    ticks(3);
    check("idle_trig_writes", wr_cnt, 0);

    // Trigger coincident with the arm rise is ignored.
    arm = 1'b1;
    tick();
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    ticks(3);
    check("arm_cycle_trig_writes", wr_cnt, 0);

    // One-shot capture, din_valid held high.
    reset_win();
    push_range(0, 15);
    pulse_ext();
    wait_done("oneshot_done", 40);
    check("oneshot_writes", wr_cnt, 16);
    check("oneshot_span", last_wr - first_wr + 1, 16);
    check("oneshot_status", status_out, 32'h8000_000F);
    check("oneshot_addr_wrap", {28'h0, bram_addr}, 32'h0);
    check("oneshot_we_off", {31'h0, bram_we}, 32'h0);
    check("oneshot_queue_left", exp_q.size(), 0);

    // Arm held high: triggers in DONE do nothing.
    reset_win();
    pulse_ext();
    sw_trig = 1'b1;
    ticks(3);
    sw_trig = 1'b0;
    ticks(2);
    check("done_trig_writes", wr_cnt, 0);
    check("done_status_hold", status_out, 32'h8000_000F);

    // Gapped valid: alternate din_valid every cycle.
    rearm();
    check("rearm_clear", status_out, 32'h0);
    reset_win();
    push_range(0, 15);
    din_valid = 1'b0;
    pulse_ext();
    for (int i = 0; i < 100; i++) begin
      if (status_out[31]) break;
      din_valid = ~din_valid;
      tick();
    end
    check("gapped_done", {31'h0, status_out[31]}, 32'h1);
    check("gapped_writes", wr_cnt, 16);
    check("gapped_span", last_wr - first_wr + 1, 31);
    check("gapped_status", status_out, 32'h8000_000F);

    // Programmed trigger delay of 5 via sw_trig.
    din_valid = 1'b1;
    tdly      = 8'd5;
    rearm();
    reset_win();
    push_range(0, 15);
    sw_trig = 1'b1;
    lat     = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      lat++;
      if (bram_we) break;
    end
    sw_trig = 1'b0;
    check("trig_delay_latency", lat, 7);
    check("trig_delay_first_addr", {28'h0, bram_addr}, 32'h0);
    wait_done("delay_done", 40);
    check("delay_status", status_out, 32'h8000_000F);

    // Circular capture of 20 samples, then stop.
    tdly = '0;
    circ = 1'b1;
    rearm();
    reset_win();
    push_range(0, 15);
    push_range(0, 3);
    pulse_ext();
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (bram_we) n++;
      tick();
      if (n == 20) break;
    end
    din_valid = 1'b0;
    ticks(2);
    check("circ_no_done_yet", {31'h0, status_out[31]}, 32'h0);
    stop = 1'b1;
    ticks(3);
    stop = 1'b0;
    check("circ_writes", wr_cnt, 20);
    check("circ_status", status_out, 32'hC000_0003);
    check("circ_queue_left", exp_q.size(), 0);

    // Arm rise during CAPTURE aborts back to ARMED with cleared status.
    circ = 1'b0;
    rearm();
    reset_win();
    push_range(0, 15);
    din_valid = 1'b1;
    pulse_ext();
    ticks(5);
    arm = 1'b0;
    tick();
    arm = 1'b1;
    ticks(2);
    check("abort_we", {31'h0, bram_we}, 32'h0);
    check("abort_addr", {28'h0, bram_addr}, 32'h0);
    check("abort_status", status_out, 32'h0);
    exp_q.delete();

    // Still ARMED: new capture, asynchronous reset once addr 7 is pending.
    reset_win();
    push_range(0, 15);
    pulse_ext();
    for (int i = 0; i < 40; i++) begin
      if (bram_we && bram_addr == AW'(7)) break;
      tick();
    end
    check("reach_addr7", {28'h0, bram_addr}, 32'h7);
    check("pre_reset_status", status_out, 32'h6);
    #2 user_rst_n = 1'b0;
    #1;
    check("async_rst_we", {31'h0, bram_we}, 32'h0);
    check("async_rst_status", status_out, 32'h0);
    check("async_rst_addr", {28'h0, bram_addr}, 32'h0);
    check("writes_before_reset", wr_cnt, 7);
    exp_q.delete();
    arm = 1'b0;
    @(negedge user_clk);
    user_rst_n = 1'b1;
    ticks(2);
    reset_win();
    pulse_ext();
    ticks(3);
    check("post_reset_trig_writes", wr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snap_vacc_capture_ctrl.md
Name: snap_vacc_capture_ctrl

Overview:
- Sequences one vector-accumulator snapshot capture into a snap BRAM.
- Arms on a rising edge of a software control bit, waits for a trigger, then writes 2^ADDR_W valid samples (one-shot) or loops until stopped (circular).
- Drives the BRAM address and write enable.
- Publishes a 32-bit status/address word for the simulink2ppc address register read by the PowerPC.
- Lives in the user_clk domain beside the snap BRAM and its address register.

Parameters:
- ADDR_W, 10, BRAM address width; one-shot capture length = 2^ADDR_W words.
- TRIG_DLY_W, 8, width of the programmable trigger-to-capture delay counter.

Ports:
- user_clk  in  1  capture clock; all logic rising-edge.
- user_rst_n  in  1  asynchronous active-low reset.
- ctrl_in  in  32  software control word: bit0 arm, bit1 sw_trig, bit2 circular, bit3 stop, bits[8+TRIG_DLY_W-1:8] trig_delay.
- ext_trig  in  1  datapath trigger pulse (vacc sync).
- din_valid  in  1  sample valid qualifier.
- bram_addr  out  ADDR_W  snap BRAM write address.
- bram_we  out  1  snap BRAM write enable.
- status_out  out  32  to the address register: [ADDR_W-1:0] last written address, [29:ADDR_W] zero, bit30 wrapped, bit31 done.

Behaviour:
- Reset: bram_addr=0, bram_we=0, status_out=0, state=IDLE, edge registers=0, delay counter=0, wrapped=0. Asynchronous assert; release is synchronous to user_clk.
- ctrl_in bits 0, 1 and 3 are registered once and edge-detected: rise = cur & ~prev. Only edges act; levels are ignored.
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- IDLE:
  - arm rise → ARMED.
  - Same cycle: bram_addr clears to 0, wrapped clears, status_out clears to 0 (done=0).
- ARMED:
  - Trigger = ext_trig | sw_trig rise.
  - On trigger: delay counter loads trig_delay. If trig_delay=0 → CAPTURE; otherwise → DELAY.
  - A second arm rise re-arms (no change).
- DELAY:
  - Counter decrements every cycle regardless of din_valid.
  - When the count reaches 1 → CAPTURE. Total delay is exactly trig_delay cycles.
- CAPTURE:
  - bram_we = din_valid, combinational with the registered state.
  - Each cycle with din_valid: write at bram_addr, status_out[ADDR_W-1:0] ← bram_addr, then bram_addr increments modulo 2^ADDR_W.
  - One-shot, write at addr 2^ADDR_W-1: → DONE. bram_addr stays at the wrapped value 0. status_out addr = 2^ADDR_W-1.
  - Circular, write at addr 2^ADDR_W-1: wraps to 0, sets wrapped (sticky), stays in CAPTURE.
  - Stop rise: → DONE after the current cycle. A write in that same cycle still completes.
  - Stop has priority over the terminal-write transition; the result is DONE in either case.
- DONE:
  - status_out[31]=1; bram_we=0.
  - arm rise → ARMED with the same clearing as IDLE.
- bram_we is 0 in every state except CAPTURE.
- Triggers are ignored outside ARMED. A trigger in the same cycle as an arm rise is ignored; it needs ARMED first.
- Arm rise during DELAY or CAPTURE aborts and restarts: → ARMED with clearing. Arm wins over stop in the same cycle.
- status_out is registered; no other outputs have latency beyond the state register.
- Reset mid-capture: immediate return to reset values; no partial done flag.

Test Plan:
- Reset and one-shot, ADDR_W=4:
  - Stimulus: release reset; arm rise; ext_trig; din_valid held 1.
  - Required: bram_we high exactly 16 cycles, addresses 0..15; then done=1, status_out=0x8000000F; bram_we=0 afterwards.
- Trigger delay:
  - Stimulus: trig_delay=5; sw_trig rise in ARMED.
  - Required: first bram_we exactly 5 cycles after the trigger-registration cycle; writes start at addr 0.
- Gapped valid:
  - Stimulus: din_valid 1-0-1-0 pattern.
  - Required: only valid cycles write; 16 writes span 31 cycles; final status addr 15.
- Circular with stop:
  - Stimulus: circular=1; run 20 valid samples; stop rise.
  - Required: wrapped=1; last address 3; status_out=0xC0000003.
- Edge/ordering:
  - Triggers before arm or in IDLE/DONE → no writes.
  - Holding arm high → a single arm only.
  - Arm rise during CAPTURE → bram_we drops, addr=0, state ARMED.
- Async reset mid-CAPTURE at addr 7:
  - Required: bram_we=0 and status_out=0 immediately, without waiting for a clock edge.
